// File: rtl/parity_serial_tx.sv
// Purpose: frames a byte as start, 8 LSB-first data bits, parity and stop on one serial line.
// Latency: tx drops on the accept edge; frame is 11*CLKS_PER_BIT cycles, done pulses at its end.
// Backpressure: ready is high only in IDLE; valid is ignored while a frame is in flight.
module parity_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic          par_bit;
    logic          accept;
    logic          bit_end;
    logic          tx_nxt;
    logic          done_nxt;

    assign accept  = valid && (state == IDLE);
    assign bit_end = (cnt == CNT_LAST);
    assign ready   = (state == IDLE);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && (idx == 3'd7)) state_nxt = PARITY;
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tx is registered from the next state so each bit appears on the edge that starts it.
    always_comb begin
        shift_nxt = shift;
        if ((state == DATA) && bit_end) begin
            shift_nxt = {1'b0, shift[7:1]};
        end
        tx_nxt   = 1'b1;
        done_nxt = 1'b0;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = par_bit;
            default: tx_nxt = 1'b1;
        endcase
        if ((state == STOP) && bit_end) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= 3'd0;
            shift   <= 8'd0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            tx   <= tx_nxt;
            done <= done_nxt;
            if (accept) begin
                cnt     <= '0;
                idx     <= 3'd0;
                shift   <= data;
                par_bit <= (^data) ^ PARITY_ODD;
            end else if (state != IDLE) begin
                cnt   <= bit_end ? '0 : cnt + 1'b1;
                shift <= shift_nxt;
                if ((state == DATA) && bit_end) begin
                    idx <= idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Bench for parity_serial_tx: four instances cover C=4 even, C=4 odd, C=1 even and C=3 even.
module tb_parity_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] valid_a;
    logic [7:0] data_a [4];
    logic [3:0] ready_a;
    logic [3:0] tx_a;
    logic [3:0] busy_a;
    logic [3:0] done_a;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    parity_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) u_c4e (
        .clk(clk), .rst(rst), .data(data_a[0]), .valid(valid_a[0]),
        .ready(ready_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .done(done_a[0]));
    parity_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) u_c4o (
        .clk(clk), .rst(rst), .data(data_a[1]), .valid(valid_a[1]),
        .ready(ready_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .done(done_a[1]));
    parity_serial_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) u_c1e (
        .clk(clk), .rst(rst), .data(data_a[2]), .valid(valid_a[2]),
        .ready(ready_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .done(done_a[2]));
    parity_serial_tx #(.CLKS_PER_BIT(3), .PARITY_ODD(1'b0)) u_c3e (
        .clk(clk), .rst(rst), .data(data_a[3]), .valid(valid_a[3]),
        .ready(ready_a[3]), .tx(tx_a[3]), .busy(busy_a[3]), .done(done_a[3]));

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic       par;
    } vec_t;

    vec_t vt [8];

    function automatic int cpb(input int s);
        case (s)
            2:       return 1;
            3:       return 3;
            default: return 4;
        endcase
    endfunction

    // Receive-side check: 1 means parity error.
    function automatic logic paritychecker(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one byte and deserialises the line at bit centres; checks handshake timing too.
    task automatic send_frame(input int s, input logic [7:0] d, input logic exp_par,
                              output logic [10:0] fr);
        int c;
        logic [10:0] exp_fr;
        c  = cpb(s);
        fr = '0;
        chk("pre_ready", 32'(ready_a[s]), 32'd1);
        data_a[s]  = d;
        valid_a[s] = 1'b1;
        step();
        valid_a[s] = 1'b0;
        data_a[s]  = ~d;
        for (int n = 0; n <= 11 * c + 1; n++) begin
            if ((n < 11 * c) && ((n % c) == (c / 2))) fr[n / c] = tx_a[s];
            if (n == 0) begin
                chk("busy_rise", 32'(busy_a[s]), 32'd1);
                chk("ready_fall", 32'(ready_a[s]), 32'd0);
            end
            if (n == 11 * c - 1) chk("done_early", 32'(done_a[s]), 32'd0);
            if (n == 11 * c) begin
                chk("done_pulse", 32'(done_a[s]), 32'd1);
                chk("ready_back", 32'(ready_a[s]), 32'd1);
                chk("busy_fall", 32'(busy_a[s]), 32'd0);
            end
            if (n == 11 * c + 1) chk("done_one_cycle", 32'(done_a[s]), 32'd0);
            if (n < 11 * c + 1) step();
        end
        exp_fr = {1'b1, exp_par, d, 1'b0};
        chk("frame", 32'(fr), 32'(exp_fr));
    endtask

    initial begin
        logic [10:0] fr;
        logic [10:0] f1;
        logic [10:0] f2;
        logic [7:0]  rec;
        logic        seen;

        vt[0] = '{0, 8'hA5, 1'b0};
        vt[1] = '{0, 8'h07, 1'b1};
        vt[2] = '{1, 8'h00, 1'b1};
        vt[3] = '{1, 8'hFF, 1'b1};
        vt[4] = '{1, 8'h01, 1'b0};
        vt[5] = '{2, 8'h80, 1'b1};
        vt[6] = '{3, 8'h3C, 1'b0};
        vt[7] = '{0, 8'h5A, 1'b0};

        // Reset held with valid high must not start a frame.
        rst     = 1'b1;
        valid_a = 4'hF;
        for (int i = 0; i < 4; i++) data_a[i] = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_tx", 32'(tx_a), 32'hF);
            chk("rst_ready", 32'(ready_a), 32'hF);
            chk("rst_busy", 32'(busy_a), 32'h0);
            chk("rst_done", 32'(done_a), 32'h0);
        end
        rst     = 1'b0;
        valid_a = 4'h0;
        step();
        chk("post_rst_tx", 32'(tx_a), 32'hF);
        chk("post_rst_busy", 32'(busy_a), 32'h0);

        for (int i = 0; i < 8; i++) begin
            send_frame(vt[i].sel, vt[i].d, vt[i].par, fr);
        end

        // Back-to-back with data changing mid-frame.
        data_a[0]  = 8'h3C;
        valid_a[0] = 1'b1;
        step();
        f1 = '0;
        f2 = '0;
        for (int n = 0; n <= 90; n++) begin
            if (n == 20) data_a[0] = 8'hC3;
            if ((n < 44) && ((n % 4) == 2)) f1[n / 4] = tx_a[0];
            if ((n >= 45) && (n < 89) && (((n - 45) % 4) == 2)) f2[(n - 45) / 4] = tx_a[0];
            if (n == 43) chk("b2b_ready_low", 32'(ready_a[0]), 32'd0);
            if (n == 44) begin
                chk("b2b_done1", 32'(done_a[0]), 32'd1);
                chk("b2b_ready", 32'(ready_a[0]), 32'd1);
            end
            if (n == 45) begin
                chk("b2b_start_tx", 32'(tx_a[0]), 32'd0);
                chk("b2b_start_busy", 32'(busy_a[0]), 32'd1);
                valid_a[0] = 1'b0;
            end
            if (n == 89) chk("b2b_done2", 32'(done_a[0]), 32'd1);
            if (n < 90) step();
        end
        chk("b2b_frame1", 32'(f1), 32'({1'b1, 1'b0, 8'h3C, 1'b0}));
        chk("b2b_frame2", 32'(f2), 32'({1'b1, 1'b0, 8'hC3, 1'b0}));

        // Reset during data bit 3 aborts the frame.
        data_a[0]  = 8'hFF;
        valid_a[0] = 1'b1;
        step();
        valid_a[0] = 1'b0;
        for (int n = 0; n < 17; n++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_tx", 32'(tx_a[0]), 32'd1);
        chk("abort_busy", 32'(busy_a[0]), 32'd0);
        chk("abort_ready", 32'(ready_a[0]), 32'd1);
        chk("abort_done", 32'(done_a[0]), 32'd0);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            step();
            if (done_a[0] || !tx_a[0]) seen = 1'b1;
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        send_frame(0, 8'h5A, 1'b0, fr);

        // Loopback over every byte at C=1 and C=3.
        for (int s = 2; s <= 3; s++) begin
            for (int v = 0; v < 256; v++) begin
                send_frame(s, 8'(v), ^(8'(v)), fr);
                rec = fr[8:1];
                chk("lb_data", 32'(rec), 32'(v));
                chk("lb_pc_ok", 32'(paritychecker(rec, fr[9])), 32'd0);
                chk("lb_pc_flip", 32'(paritychecker(rec, ~fr[9])), 32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
